// File: rtl/pulse_symbol_sequencer.sv
// pulse_symbol_sequencer
//   Symbol engine for the pulse transmitter. It walks a program of 2-bit symbols
//   packed 16 per 32-bit data word. Each symbol drives a level on pulse_out for a
//   programmed number of prescaler ticks. The walk covers the window
//   start_idx..end_idx, can optionally loop, and strobes done when it completes
//   normally.
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 run enable (level): a rising edge launches, low aborts
//   loop                  restart at start_idx after end_idx
//   start_idx, end_idx    symbol index window (7 bits)
//   tick                  one-cycle prescaler strobe
//   dur_low_a/b, dur_high_a/b
//                         duration codes for symbols 00/01/10/11; code D lasts D+1 ticks
//   mem_addr, mem_data    word index pc[6:4] and the word stored there (same cycle)
//   pulse_out             registered output level
//   sym_idx               program counter
//   busy                  high while loading or counting a symbol
//   done                  one-cycle strobe on normal completion
module pulse_symbol_sequencer #(
    parameter int NUM_WORDS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        loop,
    input  logic [6:0]  start_idx,
    input  logic [6:0]  end_idx,
    input  logic        tick,
    input  logic [7:0]  dur_low_a,
    input  logic [7:0]  dur_low_b,
    input  logic [7:0]  dur_high_a,
    input  logic [7:0]  dur_high_b,
    output logic [2:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        pulse_out,
    output logic [6:0]  sym_idx,
    output logic        busy,
    output logic        done
);
    localparam int         SPACE   = NUM_WORDS * 16;
    localparam logic [7:0] SPACE_W = 8'(SPACE);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

    state_t      r_state;
    logic [6:0]  r_pc;
    logic [7:0]  r_cnt;
    logic        r_pulse;
    logic        r_busy;
    logic        r_done;
    logic        r_start_q;
    // Set once start has been seen low since reset. If start is still held
    // high when reset is released, it must fall and rise again before it can
    // launch a run.
    logic        r_armed;

    logic [1:0]  w_sym;
    logic [7:0]  w_dur;
    logic [6:0]  w_start_pc;
    logic [6:0]  w_next_pc;
    logic        w_launch;

    assign mem_addr = r_pc[6:4];

    // Symbols beyond the populated words decode as 00, so no unused word is read.
    assign w_sym = ({1'b0, r_pc} < SPACE_W) ? mem_data[{r_pc[3:0], 1'b0} +: 2] : 2'b00;

    always_comb begin
        w_dur = dur_low_a;
        case (w_sym)
            2'b00: w_dur = dur_low_a;
            2'b01: w_dur = dur_low_b;
            2'b10: w_dur = dur_high_a;
            2'b11: w_dur = dur_high_b;
            default: w_dur = dur_low_a;
        endcase
    end

    assign w_start_pc = ({1'b0, start_idx} < SPACE_W) ? start_idx : 7'd0;
    assign w_next_pc  = ({1'b0, r_pc} == SPACE_W - 8'd1) ? 7'd0 : r_pc + 7'd1;
    assign w_launch   = start & ~r_start_q & r_armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= 7'd0;
            r_cnt     <= 8'd0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_start_q <= start;
            r_done    <= 1'b0;
            if (!start) r_armed <= 1'b1;

            // An abort takes priority over everything, including a tick in this cycle.
            if (r_state != S_IDLE && !start) begin
                r_state <= S_IDLE;
                r_pulse <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_launch) begin
                            r_pc    <= w_start_pc;
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_pulse <= w_sym[1];
                        r_cnt   <= w_dur;
                        r_state <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (tick) begin
                            if (r_cnt != 8'd0) begin
                                r_cnt <= r_cnt - 8'd1;
                            end else if (r_pc == end_idx) begin
                                if (loop) begin
                                    r_pc    <= w_start_pc;
                                    r_state <= S_LOAD;
                                end else begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_pc    <= w_next_pc;
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        r_pulse <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign pulse_out = r_pulse;
    assign sym_idx   = r_pc;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_pulse_symbol_sequencer.sv
// Testbench for pulse_symbol_sequencer. A timeline model computes the expected
// output trace of each run from the symbol program and a pre-drawn tick
// schedule. Directed runs cover the listed scenarios, and random runs sweep
// windows, durations, looping and aborts.
module tb_pulse_symbol_sequencer;
    localparam int NW    = 5;
    localparam int SPACE = NW * 16;
    localparam int HMAX  = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        loop = 1'b0;
    logic        tick = 1'b0;
    logic [6:0]  start_idx = 7'd0;
    logic [6:0]  end_idx = 7'd0;
    logic [7:0]  dla = 8'd0, dlb = 8'd0, dha = 8'd0, dhb = 8'd0;
    logic [2:0]  mem_addr;
    logic [31:0] mem_data;
    logic        pulse_out, busy, done;
    logic [6:0]  sym_idx;
    logic [31:0] mem [8];

    int total = 0;
    int bad = 0;
    int run_no = 0;
    int cyc = 0;

    // Expected values after each clock edge of a run; edge 0 is the launch edge.
    int tk  [HMAX];
    int e_p [HMAX];
    int e_b [HMAX];
    int e_d [HMAX];
    int e_i [HMAX];

    pulse_symbol_sequencer #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .loop(loop),
        .start_idx(start_idx), .end_idx(end_idx), .tick(tick),
        .dur_low_a(dla), .dur_low_b(dlb), .dur_high_a(dha), .dur_high_b(dhb),
        .mem_addr(mem_addr), .mem_data(mem_data), .pulse_out(pulse_out),
        .sym_idx(sym_idx), .busy(busy), .done(done)
    );

    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (run %0d cycle %0d)", tag, got, exp, run_no, cyc);
        end
    endtask

    function automatic int sym_of(input int pc);
        if (pc >= SPACE) return 0;
        return int'((mem[pc / 16] >> (2 * (pc % 16))) & 32'h3);
    endfunction

    function automatic int ticks_of(input int s);
        case (s)
            0: return int'(dla) + 1;
            1: return int'(dlb) + 1;
            2: return int'(dha) + 1;
            default: return int'(dhb) + 1;
        endcase
    endfunction

    // Walk the program symbol by symbol. The first symbol is loaded at edge 1.
    // Each symbol consumes its tick quota from ticks at edges after its load
    // edge. The edge of the last tick moves pc on (the next load follows one
    // edge later) or, at the end of a non-looping window, raises done.
    task automatic build(input int h, input int abort_at);
        int pc, L, t, n, s, lvl;
        bit fin;
        pc = (int'(start_idx) >= SPACE) ? 0 : int'(start_idx);
        for (int c = 0; c < h; c++) begin
            e_p[c] = 0; e_b[c] = 0; e_d[c] = 0; e_i[c] = pc;
        end
        e_b[0] = 1;
        L = 1;
        fin = 1'b0;
        while (!fin && L < h) begin
            s = sym_of(pc);
            lvl = s / 2;
            n = 0;
            t = L;
            while (n < ticks_of(s)) begin
                t++;
                if (t >= h) break;
                if (tk[t] != 0) n++;
            end
            for (int c = L; c < t && c < h; c++) begin
                e_p[c] = lvl; e_b[c] = 1; e_d[c] = 0; e_i[c] = pc;
            end
            if (t >= h) break;
            if (pc == int'(end_idx) && !loop) begin
                e_p[t] = lvl; e_b[t] = 0; e_d[t] = 1; e_i[t] = pc;
                for (int c = t + 1; c < h; c++) begin
                    e_p[c] = 0; e_b[c] = 0; e_d[c] = 0; e_i[c] = pc;
                end
                fin = 1'b1;
            end else begin
                if (pc == int'(end_idx)) pc = (int'(start_idx) >= SPACE) ? 0 : int'(start_idx);
                else pc = (pc + 1 == SPACE) ? 0 : pc + 1;
                e_p[t] = lvl; e_b[t] = 1; e_d[t] = 0; e_i[t] = pc;
                L = t + 1;
            end
        end
        // An abort returns to idle and clears the output, but pc is left unchanged.
        for (int c = abort_at; c < h; c++) begin
            e_p[c] = 0; e_b[c] = 0; e_d[c] = 0; e_i[c] = e_i[abort_at - 1];
        end
    endtask

    // tmode: 0 random ticks, 1 a tick every 4th clock, 2 a tick every clock
    task automatic run(input int tmode, input int h, input int abort_at, input bit keep_start);
        run_no++;
        for (int c = 0; c < h; c++) begin
            if (tmode == 0) tk[c] = int'($urandom_range(0, 1));
            else if (tmode == 1) tk[c] = (c % 4 == 3) ? 1 : 0;
            else tk[c] = 1;
        end
        if (abort_at < h) tk[abort_at] = 1;
        build(h, abort_at);
        start = 1'b0;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc = -1;
        chk("idle_busy", int'(busy), 0);
        for (int c = 0; c < h; c++) begin
            start = (c < abort_at);
            tick = tk[c][0];
            @(posedge clk);
            #1;
            cyc = c;
            chk("pulse_out", int'(pulse_out), e_p[c]);
            chk("busy", int'(busy), e_b[c]);
            chk("done", int'(done), e_d[c]);
            chk("sym_idx", int'(sym_idx), e_i[c]);
            chk("mem_addr", int'(mem_addr), e_i[c] / 16);
        end
        if (!keep_start) start = 1'b0;
        tick = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        mem[5] = $urandom; mem[6] = $urandom; mem[7] = $urandom;
        dla = 8'd0; dlb = 8'd0; dha = 8'd0; dhb = 8'd0;
        loop = 1'b0;
    endtask

    initial begin
        clear_cfg();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulse", int'(pulse_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(sym_idx), 0);
        chk("rst_addr", int'(mem_addr), 0);
        rst_n = 1'b1;

        // single high symbol lasting 4 ticks
        clear_cfg(); mem[0] = 32'h2; dha = 8'd3; start_idx = 7'd0; end_idx = 7'd0;
        run(1, 40, 40, 1'b0);

        // crossing from word 0 into word 1
        clear_cfg(); mem[0] = 32'hC000_0000; mem[1] = 32'h1; dhb = 8'd0; dlb = 8'd1;
        start_idx = 7'd15; end_idx = 7'd16;
        run(2, 20, 20, 1'b0);

        // looping two-symbol window, ended by an abort
        clear_cfg(); mem[0] = 32'h20; loop = 1'b1; start_idx = 7'd2; end_idx = 7'd3;
        run(2, 40, 30, 1'b0);

        // abort on a tick mid-count, followed by a relaunch
        clear_cfg(); mem[0] = 32'h2; dha = 8'd20; start_idx = 7'd0; end_idx = 7'd0;
        run(0, 40, 25, 1'b0);
        run(0, 60, 60, 1'b0);

        // window wrapping through 0, then a start index outside the symbol space
        clear_cfg(); mem[4] = 32'h8000_0000; mem[0] = 32'h3; dha = 8'd1; dhb = 8'd2;
        start_idx = 7'd79; end_idx = 7'd0;
        run(2, 30, 30, 1'b0);
        start_idx = 7'd100; end_idx = 7'd1;
        run(2, 30, 30, 1'b0);

        // reset mid-run with start held high; no relaunch until start toggles
        clear_cfg(); mem[0] = 32'h2; dha = 8'd50; start_idx = 7'd1; end_idx = 7'd1;
        mem[0] = 32'h8;
        run(2, 10, 10, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc = 100;
        chk("mrst_pulse", int'(pulse_out), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_idx", int'(sym_idx), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            cyc = 101 + i;
            chk("held_start_busy", int'(busy), 0);
        end
        run(2, 20, 20, 1'b0);

        // random programs, windows and aborts
        for (int r = 0; r < 20; r++) begin
            int ab;
            for (int i = 0; i < 8; i++) mem[i] = $urandom;
            dla = 8'($urandom_range(0, 7)); dlb = 8'($urandom_range(0, 7));
            dha = 8'($urandom_range(0, 7)); dhb = 8'($urandom_range(0, 7));
            start_idx = 7'($urandom_range(0, 85));
            if ($urandom_range(0, 3) == 0) end_idx = 7'($urandom_range(0, 127));
            else end_idx = 7'((int'(start_idx) + int'($urandom_range(0, 5))) % SPACE);
            loop = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 299)) : 300;
            run(0, 300, ab, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
